// File: rtl/sr_cfg_loader.sv
// sr_cfg_loader
// Serial loader for two external configuration shift registers: a static
// register of SIZESRSTAT bits and a dynamic register of SIZESRDYN bits.
// A request is accepted with a valid/ready handshake. The word is then
// shifted out MSB-first on sdo while the matching sel_* line is high. A
// one-cycle latch/done strobe follows, then GAP_CYCLES idle cycles.
//
// Ports
//   CLK                    system clock, rising edge
//   RST_N                  asynchronous active-low reset
//   stat_valid / stat_data static load request and its word
//   stat_ready             static request accepted this cycle
//   dyn_valid / dyn_data   dynamic load request and its word
//   dyn_ready              dynamic request accepted this cycle
//   sdo                    serial data, MSB-first
//   sel_stat / sel_dyn     shift enable for the static / dynamic register
//   latch / done           one-cycle strobe after the last shifted bit
//   busy                   high whenever the loader is not idle
module sr_cfg_loader #(
  parameter int SIZESRSTAT = 88,
  parameter int SIZESRDYN  = 16,
  parameter int GAP_CYCLES = 8
) (
  input  logic                  CLK,
  input  logic                  RST_N,
  input  logic                  stat_valid,
  input  logic [SIZESRSTAT-1:0] stat_data,
  output logic                  stat_ready,
  input  logic                  dyn_valid,
  input  logic [SIZESRDYN-1:0]  dyn_data,
  output logic                  dyn_ready,
  output logic                  sdo,
  output logic                  sel_stat,
  output logic                  sel_dyn,
  output logic                  latch,
  output logic                  done,
  output logic                  busy
);

  localparam int MAXW = (SIZESRSTAT > SIZESRDYN) ? SIZESRSTAT : SIZESRDYN;
  localparam int CW   = $clog2(MAXW) + 1;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    LATCH = 2'd2,
    GAP   = 2'd3
  } state_t;

  state_t          state_q, state_d;
  logic [CW-1:0]   bit_cnt_q, bit_cnt_d;
  logic [7:0]      gap_cnt_q, gap_cnt_d;
  logic [MAXW-1:0] buf_q, buf_d;
  logic            tgt_stat_q, tgt_stat_d;
  logic            sdo_q, sdo_d;
  logic            sel_stat_q, sel_stat_d;
  logic            sel_dyn_q, sel_dyn_d;
  logic            latch_q, latch_d;
  logic            done_q, done_d;
  logic            busy_q, busy_d;

  logic            stat_hs_s;
  logic            dyn_hs_s;
  logic [MAXW-1:0] stat_al_s;
  logic [MAXW-1:0] dyn_al_s;
  logic [MAXW-1:0] buf_shl_s;

  // Ready is decoded from registered state; static always wins over dynamic.
  assign stat_ready = (state_q == IDLE);
  assign dyn_ready  = (state_q == IDLE) && !stat_valid;
  assign stat_hs_s  = stat_valid && stat_ready;
  assign dyn_hs_s   = dyn_valid && dyn_ready;

  // Left-align both words in the shared buffer so the MSB is always buf[MAXW-1].
  assign stat_al_s  = MAXW'(stat_data) << (MAXW - SIZESRSTAT);
  assign dyn_al_s   = MAXW'(dyn_data) << (MAXW - SIZESRDYN);
  assign buf_shl_s  = buf_q << 1;

  assign sdo      = sdo_q;
  assign sel_stat = sel_stat_q;
  assign sel_dyn  = sel_dyn_q;
  assign latch    = latch_q;
  assign done     = done_q;
  assign busy     = busy_q;

  // Next-state and next-output computation for the loader FSM.
  always_comb begin
    state_d    = state_q;
    bit_cnt_d  = bit_cnt_q;
    gap_cnt_d  = gap_cnt_q;
    buf_d      = buf_q;
    tgt_stat_d = tgt_stat_q;
    sdo_d      = 1'b0;
    sel_stat_d = 1'b0;
    sel_dyn_d  = 1'b0;
    latch_d    = 1'b0;
    done_d     = 1'b0;
    case (state_q)
      IDLE: begin
        // The first bit is presented in the cycle right after the handshake.
        // The counter therefore holds the number of SHIFT cycles still to go.
        if (stat_hs_s) begin
          state_d    = SHIFT;
          buf_d      = stat_al_s;
          tgt_stat_d = 1'b1;
          bit_cnt_d  = CW'(SIZESRSTAT - 1);
          sdo_d      = stat_al_s[MAXW-1];
          sel_stat_d = 1'b1;
        end else if (dyn_hs_s) begin
          state_d    = SHIFT;
          buf_d      = dyn_al_s;
          tgt_stat_d = 1'b0;
          bit_cnt_d  = CW'(SIZESRDYN - 1);
          sdo_d      = dyn_al_s[MAXW-1];
          sel_dyn_d  = 1'b1;
        end else begin
          state_d    = IDLE;
        end
      end
      SHIFT: begin
        if (bit_cnt_q == {CW{1'b0}}) begin
          state_d = LATCH;
          latch_d = 1'b1;
          done_d  = 1'b1;
        end else begin
          bit_cnt_d  = bit_cnt_q - CW'(1);
          buf_d      = buf_shl_s;
          sdo_d      = buf_shl_s[MAXW-1];
          sel_stat_d = tgt_stat_q;
          sel_dyn_d  = !tgt_stat_q;
        end
      end
      LATCH: begin
        state_d   = GAP;
        gap_cnt_d = 8'(GAP_CYCLES - 1);
      end
      GAP: begin
        if (gap_cnt_q == 8'd0) begin
          state_d = IDLE;
        end else begin
          gap_cnt_d = gap_cnt_q - 8'd1;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
    busy_d = (state_d != IDLE);
  end

  // State, counters, buffer and registered outputs.
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      state_q    <= IDLE;
      bit_cnt_q  <= {CW{1'b0}};
      gap_cnt_q  <= 8'd0;
      buf_q      <= {MAXW{1'b0}};
      tgt_stat_q <= 1'b0;
      sdo_q      <= 1'b0;
      sel_stat_q <= 1'b0;
      sel_dyn_q  <= 1'b0;
      latch_q    <= 1'b0;
      done_q     <= 1'b0;
      busy_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      bit_cnt_q  <= bit_cnt_d;
      gap_cnt_q  <= gap_cnt_d;
      buf_q      <= buf_d;
      tgt_stat_q <= tgt_stat_d;
      sdo_q      <= sdo_d;
      sel_stat_q <= sel_stat_d;
      sel_dyn_q  <= sel_dyn_d;
      latch_q    <= latch_d;
      done_q     <= done_d;
      busy_q     <= busy_d;
    end
  end

endmodule

// File: doc/sr_cfg_loader.md
SR_CFG_LOADER -- requirements
Module: sr_cfg_loader

Interface
REQ-001 The block SHALL have parameter SIZESRSTAT, default 88, meaning static shift register length in bits.
REQ-002 The block SHALL have parameter SIZESRDYN, default 16, meaning dynamic shift register length in bits.
REQ-003 The block SHALL have parameter GAP_CYCLES, default 8, meaning the idle cycles enforced after each latch, valid range 1..255.
REQ-004 The block SHALL have port CLK, input, width 1, the system clock; all state changes on the rising edge.
REQ-005 The block SHALL have port RST_N, input, width 1, reset, asynchronous, active-low.
REQ-006 The block SHALL have port stat_valid, input, width 1, a static load request with stat_data valid.
REQ-007 The block SHALL have port stat_data, input, width SIZESRSTAT, the static configuration word.
REQ-008 The block SHALL have port stat_ready, output, width 1, meaning the static request is accepted this cycle if stat_valid=1.
REQ-009 The block SHALL have port dyn_valid, input, width 1, a dynamic load request with dyn_data valid.
REQ-010 The block SHALL have port dyn_data, input, width SIZESRDYN, the dynamic configuration word.
REQ-011 The block SHALL have port dyn_ready, output, width 1, meaning the dynamic request is accepted this cycle if dyn_valid=1.
REQ-012 The block SHALL have port sdo, output, width 1, the serial data to the selected shift register.
REQ-013 The block SHALL have port sel_stat, output, width 1, which shifts the static register while high.
REQ-014 The block SHALL have port sel_dyn, output, width 1, which shifts the dynamic register while high.
REQ-015 The block SHALL have port latch, output, width 1, a one-cycle parallel-latch strobe for the register just shifted.
REQ-016 The block SHALL have port done, output, width 1, a one-cycle pulse coincident with latch.
REQ-017 The block SHALL have port busy, output, width 1, high whenever the state is not IDLE.

Function
REQ-018 The FSM SHALL have exactly four states: IDLE, SHIFT, LATCH and GAP.
REQ-019 In IDLE, stat_ready SHALL be 1; dyn_ready SHALL equal !stat_valid, so static has fixed priority.
REQ-020 In every state other than IDLE, stat_ready and dyn_ready SHALL both be 0.
REQ-021 On a handshake (valid&ready), the block SHALL capture the data word into the internal shift buffer and record the target (stat or dyn), then go IDLE->SHIFT.
REQ-022 SHIFT SHALL last exactly N cycles, where N=SIZESRSTAT for static and N=SIZESRDYN for dynamic; the bit counter width SHALL be clog2(max(SIZESRSTAT,SIZESRDYN))+1.
REQ-023 During SHIFT, only the selected sel_* SHALL be 1; sdo SHALL present the data MSB-first, with bit N-1-i on the i-th SHIFT cycle (i=0..N-1).
REQ-024 SHIFT SHALL go to LATCH after the N-th cycle; LATCH SHALL last 1 cycle with latch=1, done=1, sel_stat=sel_dyn=0.
REQ-025 LATCH SHALL go to GAP; GAP SHALL last exactly GAP_CYCLES cycles with all strobes 0, then return to IDLE.
REQ-026 Outside SHIFT, sdo SHALL be 0.
REQ-027 All outputs SHALL be registered or decoded only from registered state, and SHALL be glitch-free.
REQ-028 sel_stat and sel_dyn SHALL never both be 1 in the same cycle.
REQ-029 Latency: for a handshake at edge k, the first sel_* cycle SHALL be k+1, latch SHALL be at k+N+1, and ready SHALL reassert at k+N+2+GAP_CYCLES.
REQ-030 If both valids are held, the transfers SHALL complete in the order static, then dynamic; valid deasserting before its handshake SHALL cancel that request silently.
REQ-031 Changes to stat_data or dyn_data after the handshake SHALL NOT affect the transfer in progress.

Reset
REQ-032 While RST_N=0, the state SHALL be IDLE, all counters and the buffer SHALL be 0, and sdo, sel_stat, sel_dyn, latch, done and busy SHALL be 0.
REQ-033 Reset asserted mid-SHIFT SHALL abort the transfer with no latch pulse; after release, the block SHALL be in IDLE with stat_ready=1 on the first cycle.
REQ-034 Reset release SHALL be synchronous to CLK (deassertion sampled at an edge); no handshake SHALL occur in a cycle where RST_N=0.

Verification
REQ-035 Scenario: dyn_valid=1, dyn_data=16'h8001, stat_valid=0 -> sel_dyn high 16 cycles, sdo=1,0x14,1, latch+done at k+17, ready again at k+26.
REQ-036 Scenario: stat_valid=1, stat_data=88'hA5 followed by zeros (pattern in the top byte) -> sel_stat high 88 cycles, first 8 sdo bits 1,0,1,0,0,1,0,1, latch at k+89.
REQ-037 Scenario: stat_valid and dyn_valid asserted together in IDLE -> static shifts first; dyn_ready=0 until GAP ends; dynamic handshake at k+98; sel signals never overlap.
REQ-038 Scenario: RST_N pulled low at SHIFT cycle 40 of a static load -> all outputs 0 immediately, no latch; after release, a dyn request completes normally.
REQ-039 Scenario: stat_data changed every cycle after the handshake -> the serialized bits match the captured word.
REQ-040 Scenario: dyn_valid pulsed while busy, dropped before IDLE -> no transfer occurs, and no latch follows the current one.
